// File: rtl/cl_pkg.sv
// Shared constants and helpers for the Camera Link frame/line monitor.
package cl_pkg;

  localparam int NTAPS   = 10;
  localparam int TAP_W   = 8;
  localparam int LINE_W  = 12;
  localparam int FRAME_W = 16;

  localparam logic [LINE_W-1:0] LINE_MAX = '1;
  localparam logic [LINE_W-1:0] NTAPS_L  = LINE_W'(NTAPS);
  localparam logic [LINE_W-1:0] ONE_L    = LINE_W'(1);

  // Unsigned add that clamps at the counter's full-scale value.
  function automatic logic [LINE_W-1:0] sat_add(input logic [LINE_W-1:0] a,
                                                input logic [LINE_W-1:0] b);
    logic [LINE_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[LINE_W] ? LINE_MAX : sum[LINE_W-1:0];
  endfunction

endpackage

// File: rtl/cl_max10.sv
// Combinational unsigned maximum of all pixel taps presented in one clock.
module cl_max10
  import cl_pkg::*;
(
  input  logic [NTAPS-1:0][TAP_W-1:0] taps,
  output logic [TAP_W-1:0]            max_val
);

  always_comb begin
    max_val = '0;
    for (int i = 0; i < NTAPS; i++) begin
      if (taps[i] > max_val) max_val = taps[i];
    end
  end

endmodule

// File: rtl/cl.sv
// Camera Link base/medium/full monitor: counts frames, lines and pixels,
// tracks per-frame peak pixel value and flags geometry / LVAL skew errors.
module cl
  import cl_pkg::*;
(
  input  logic             reset,
  input  logic             cl_fval,
  input  logic             cl_x_pclk,
  input  logic             cl_x_lval,
  input  logic             cl_y_pclk,
  input  logic             cl_y_lval,
  input  logic             cl_z_pclk,
  input  logic             cl_z_lval,
  input  logic [TAP_W-1:0] cl_port_a,
  input  logic [TAP_W-1:0] cl_port_b,
  input  logic [TAP_W-1:0] cl_port_c,
  input  logic [TAP_W-1:0] cl_port_d,
  input  logic [TAP_W-1:0] cl_port_e,
  input  logic [TAP_W-1:0] cl_port_f,
  input  logic [TAP_W-1:0] cl_port_g,
  input  logic [TAP_W-1:0] cl_port_h,
  input  logic [TAP_W-1:0] cl_port_i,
  input  logic [TAP_W-1:0] cl_port_j,
  output logic [7:0]       led8
);

  logic                       fval_s1, xl_s1, yl_s1, zl_s1;
  logic [NTAPS-1:0][TAP_W-1:0] taps_s1;
  logic                       fval_d, xl_d, s1_valid, armed, in_frame, have_line;
  logic [FRAME_W-1:0]         frame_cnt;
  logic [LINE_W-1:0]          line_cnt, pix_cnt, line_length, lines_per_frame;
  logic [TAP_W-1:0]           run_max, frame_max, tap_max;
  logic                       geom_err, lval_err;
  logic                       fval_rise, xl_rise, xl_fall;
  logic                       unused_bits;

  cl_max10 u_max10 (
    .taps    (taps_s1),
    .max_val (tap_max)
  );

  assign fval_rise = fval_s1 & ~fval_d;
  assign xl_rise   = xl_s1 & ~xl_d;
  assign xl_fall   = ~xl_s1 & xl_d;

  assign unused_bits = ^{cl_y_pclk, cl_z_pclk, lines_per_frame,
                         frame_max[3:0], frame_cnt[FRAME_W-1:1]};

  // A frame only counts once FVAL has been seen low after reset, so releasing
  // reset in the middle of a frame never produces a partial frame.
  always_ff @(posedge cl_x_pclk or negedge reset) begin
    if (!reset) begin
      fval_s1         <= 1'b0;
      xl_s1           <= 1'b0;
      yl_s1           <= 1'b0;
      zl_s1           <= 1'b0;
      taps_s1         <= '0;
      fval_d          <= 1'b0;
      xl_d            <= 1'b0;
      s1_valid        <= 1'b0;
      armed           <= 1'b0;
      in_frame        <= 1'b0;
      have_line       <= 1'b0;
      frame_cnt       <= '0;
      line_cnt        <= '0;
      pix_cnt         <= '0;
      line_length     <= '0;
      lines_per_frame <= '0;
      run_max         <= '0;
      frame_max       <= '0;
      geom_err        <= 1'b0;
      lval_err        <= 1'b0;
      led8            <= '0;
    end else begin
      fval_s1  <= cl_fval;
      xl_s1    <= cl_x_lval;
      yl_s1    <= cl_y_lval;
      zl_s1    <= cl_z_lval;
      taps_s1  <= {cl_port_j, cl_port_i, cl_port_h, cl_port_g, cl_port_f,
                   cl_port_e, cl_port_d, cl_port_c, cl_port_b, cl_port_a};
      fval_d   <= fval_s1;
      xl_d     <= xl_s1;
      s1_valid <= 1'b1;
      armed    <= armed | (s1_valid & ~fval_s1);

      if ((xl_s1 != yl_s1) || (xl_s1 != zl_s1)) lval_err <= 1'b1;

      if (fval_rise) begin
        if (armed) begin
          frame_cnt <= frame_cnt + 1'b1;
          in_frame  <= 1'b1;
          line_cnt  <= '0;
          pix_cnt   <= '0;
          run_max   <= '0;
          have_line <= 1'b0;
        end
      end else if (in_frame) begin
        if (xl_rise && fval_s1) line_cnt <= sat_add(line_cnt, ONE_L);
        if (xl_s1 && fval_s1) begin
          pix_cnt <= xl_rise ? NTAPS_L : sat_add(pix_cnt, NTAPS_L);
          if (tap_max > run_max) run_max <= tap_max;
        end
        // Line close is handled before frame close when both fall together.
        if (xl_fall) begin
          line_length <= pix_cnt;
          have_line   <= 1'b1;
          if (have_line && (pix_cnt != line_length)) geom_err <= 1'b1;
        end
        if (!fval_s1) begin
          in_frame        <= 1'b0;
          lines_per_frame <= line_cnt;
          frame_max       <= run_max;
        end
      end

      led8 <= {frame_cnt[0], lval_err, geom_err, fval_d, frame_max[7:4]};
    end
  end

endmodule

// File: tb/tb_cl.sv
// Directed self-checking bench for the Camera Link monitor.
module tb_cl;

  logic       reset;
  logic       clk;
  logic       fval, xl, yl, zl;
  logic [7:0] taps [10];
  logic [7:0] led8;
  int         checks;
  int         errors;

  cl dut (
    .reset     (reset),
    .cl_fval   (fval),
    .cl_x_pclk (clk),
    .cl_x_lval (xl),
    .cl_y_pclk (clk),
    .cl_y_lval (yl),
    .cl_z_pclk (clk),
    .cl_z_lval (zl),
    .cl_port_a (taps[0]),
    .cl_port_b (taps[1]),
    .cl_port_c (taps[2]),
    .cl_port_d (taps[3]),
    .cl_port_e (taps[4]),
    .cl_port_f (taps[5]),
    .cl_port_g (taps[6]),
    .cl_port_h (taps[7]),
    .cl_port_i (taps[8]),
    .cl_port_j (taps[9]),
    .led8      (led8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Inputs change on the falling edge so every sample is away from the active edge.
  task automatic applyStimulus(input logic f, input logic x, input logic y,
                               input logic z, input int n);
    fval = f;
    xl   = x;
    yl   = y;
    zl   = z;
    repeat (n) @(negedge clk);
  endtask

  task automatic setTaps(input logic [7:0] v);
    for (int i = 0; i < 10; i++) taps[i] = v;
  endtask

  task automatic runLine(input int len);
    applyStimulus(1, 1, 1, 1, len);
    applyStimulus(1, 0, 0, 0, 2);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    setTaps(8'h00);
    applyStimulus(0, 0, 0, 0, 3);
    checkOutput("reset_led8", led8, 32'h00);

    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 4);
    checkOutput("idle_led8", led8, 32'h00);
    checkOutput("idle_frame_cnt", dut.frame_cnt, 0);
    checkOutput("idle_line_cnt", dut.line_cnt, 0);
    checkOutput("idle_pix_cnt", dut.pix_cnt, 0);

    // Frame A: 4 lines of 3 LVAL cycles, all taps 0x10
    setTaps(8'h10);
    applyStimulus(1, 0, 0, 0, 2);
    for (int l = 0; l < 4; l++) runLine(3);
    applyStimulus(0, 0, 0, 0, 4);
    checkOutput("a_line_length", dut.line_length, 30);
    checkOutput("a_lines_per_frame", dut.lines_per_frame, 4);
    checkOutput("a_led8", led8, 32'h81);

    // Frame B: lines of 3,3,2 cycles with a single 0xA5 on the last tap
    setTaps(8'h00);
    applyStimulus(1, 0, 0, 0, 2);
    applyStimulus(1, 1, 1, 1, 1);
    taps[9] = 8'hA5;
    applyStimulus(1, 1, 1, 1, 1);
    taps[9] = 8'h00;
    applyStimulus(1, 1, 1, 1, 1);
    applyStimulus(1, 0, 0, 0, 2);
    runLine(3);
    applyStimulus(1, 1, 1, 1, 2);
    applyStimulus(1, 0, 0, 0, 1);
    checkOutput("b_geom_not_yet", dut.geom_err, 0);
    applyStimulus(1, 0, 0, 0, 1);
    checkOutput("b_led5_not_yet", led8[5], 0);
    applyStimulus(1, 0, 0, 0, 1);
    checkOutput("b_led5_set", led8[5], 1);
    applyStimulus(0, 0, 0, 0, 4);
    checkOutput("b_led8", led8, 32'h2A);
    checkOutput("b_line_length", dut.line_length, 20);
    checkOutput("b_lines_per_frame", dut.lines_per_frame, 3);

    // LVAL activity outside a frame is ignored
    for (int p = 0; p < 3; p++) begin
      applyStimulus(0, 1, 1, 1, 2);
      applyStimulus(0, 0, 0, 0, 2);
    end
    checkOutput("nofval_frame_cnt", dut.frame_cnt, 2);
    checkOutput("nofval_line_cnt", dut.line_cnt, 3);
    checkOutput("nofval_line_length", dut.line_length, 20);
    checkOutput("nofval_led8", led8, 32'h2A);

    // Y LVAL drops for one cycle while X and Z stay high
    applyStimulus(0, 1, 1, 1, 2);
    applyStimulus(0, 1, 0, 1, 1);
    applyStimulus(0, 1, 1, 1, 2);
    applyStimulus(0, 0, 0, 0, 3);
    checkOutput("skew_led8", led8, 32'h6A);

    // Frame C: lval_err must persist; first tap 0x33
    setTaps(8'h00);
    taps[0] = 8'h33;
    applyStimulus(1, 0, 0, 0, 2);
    runLine(2);
    runLine(2);
    applyStimulus(0, 0, 0, 0, 4);
    checkOutput("c_led8", led8, 32'hE3);
    checkOutput("c_lines_per_frame", dut.lines_per_frame, 2);
    checkOutput("c_line_length", dut.line_length, 20);

    // Reset mid-line, released while FVAL is still high
    applyStimulus(1, 0, 0, 0, 2);
    applyStimulus(1, 1, 1, 1, 1);
    #2 reset = 1'b0;
    #1 checkOutput("midreset_led8", led8, 32'h00);
    checkOutput("midreset_lval_err", dut.lval_err, 0);
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(1, 1, 1, 1, 2);
    applyStimulus(1, 0, 0, 0, 2);
    runLine(2);
    applyStimulus(0, 0, 0, 0, 4);
    checkOutput("partial_frame_cnt", dut.frame_cnt, 0);
    checkOutput("partial_line_cnt", dut.line_cnt, 0);
    checkOutput("partial_lines_per_frame", dut.lines_per_frame, 0);
    checkOutput("partial_led8", led8, 32'h00);

    // Frame D: first counted frame after reset
    setTaps(8'hF0);
    applyStimulus(1, 0, 0, 0, 2);
    runLine(4);
    applyStimulus(0, 0, 0, 0, 4);
    checkOutput("d_frame_cnt", dut.frame_cnt, 1);
    checkOutput("d_line_length", dut.line_length, 40);
    checkOutput("d_lines_per_frame", dut.lines_per_frame, 1);
    checkOutput("d_led8", led8, 32'h8F);

    // Frame E: a very long line saturates the pixel counter
    setTaps(8'h00);
    applyStimulus(1, 0, 0, 0, 2);
    runLine(420);
    applyStimulus(0, 0, 0, 0, 4);
    checkOutput("e_line_length_sat", dut.line_length, 4095);
    checkOutput("e_frame_cnt", dut.frame_cnt, 2);
    checkOutput("e_led8", led8, 32'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cl.md
CL -- requirements
Module: cl

Interface
REQ-001 SHALL have ports: cl_x_pclk  in  1  sole clock, Camera Link X pixel clock; all logic on its rising edge.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: cl_fval  in  1  frame valid.
REQ-004 SHALL have ports: cl_x_lval, cl_y_lval, cl_z_lval  in  1 each  line valid per channel; all sampled on cl_x_pclk.
REQ-005 SHALL have ports: cl_y_pclk, cl_z_pclk  in  1 each  unused; the block SHALL NOT clock anything on them.
REQ-006 SHALL have ports: cl_port_a..cl_port_j  in  8 each  ten pixel taps, a = first pixel.
REQ-007 SHALL have ports: led8  out  8  registered status display.
REQ-008 Port order SHALL be: reset, cl_fval, cl_x_pclk, cl_x_lval, cl_y_pclk, cl_y_lval, cl_z_pclk, cl_z_lval, cl_port_a..j, led8.
REQ-009 Constants SHALL be: NTAPS = 10 (taps per clock); TAP_W = 8; LINE_W = 12 (line and pixel counters); FRAME_W = 16 (frame counter).

Function
REQ-010 All inputs SHALL be registered once (stage S1); edges SHALL be detected by comparing S1 with its one-cycle-delayed copy.
REQ-011 The frame counter (FRAME_W) SHALL increment on each FVAL rising edge, wrapping from 0xFFFF to 0.
REQ-012 On FVAL rise, the line counter, pixel counter, running maximum and first-line flag SHALL clear.
REQ-013 While FVAL = 1, each X-LVAL rising edge SHALL increment the line counter, saturating at 4095.
REQ-014 While FVAL = 1 and X-LVAL = 1, the pixel counter SHALL add NTAPS per clock, saturating at 4095.
REQ-015 The pixel counter SHALL restart at NTAPS on the first LVAL cycle of each line.
REQ-016 On X-LVAL fall, line_length SHALL latch the pixel count; the line counter SHALL not change.
REQ-017 On X-LVAL fall, if a prior line in the same frame exists and its length differs, the sticky geom_err SHALL set.
REQ-018 LVAL activity while FVAL = 0 SHALL be ignored: no counting, no latching, no error.
REQ-019 The running maximum SHALL update to the unsigned maximum of all ten taps on every cycle with FVAL & X-LVAL.
REQ-020 On FVAL fall, lines_per_frame SHALL latch the line counter and frame_max SHALL latch the running maximum.
REQ-021 If FVAL and LVAL fall on the same cycle, REQ-016/017 SHALL apply before REQ-020.
REQ-022 Any S1 cycle with cl_x_lval ≠ cl_y_lval or cl_x_lval ≠ cl_z_lval SHALL set the sticky lval_err, regardless of FVAL.
REQ-023 Sticky errors SHALL clear only by reset.
REQ-024 led8 SHALL be registered: [7] = frame_count[0]; [6] = lval_err; [5] = geom_err; [4] = delayed FVAL S1; [3:0] = frame_max[7:4].
REQ-025 Latency SHALL be: input sampled at edge N → internal state at N+1 → led8 at N+2.

Reset
REQ-026 While reset = 0, all registers (S1, delays, counters, latches, sticky errors, led8) SHALL be 0 immediately, asynchronously.
REQ-027 Reset release mid-frame with FVAL = 1 SHALL NOT count a frame; the next FVAL rise SHALL count a frame.

Structure
REQ-028 NTAPS, TAP_W, LINE_W and FRAME_W SHALL live in shared package cl_pkg.
REQ-029 The ten-input unsigned max tree SHALL be a combinational sub-module cl_max10.
REQ-030 All other logic SHALL be flat in cl.

Verification
REQ-031 Reset low then high, inputs idle → led8 = 0x00; all counters 0.
REQ-032 One frame of 4 lines × 3 LVAL cycles, taps = 0x10 → line_length = 30; lines_per_frame = 4; led8 = 0x81 after FVAL fall.
REQ-033 cl_y_lval low for one cycle while x/z high → led8[6] = 1; stays 1 across the next frame.
REQ-034 Same frame with lines of 3, 3, 2 cycles → led8[5] = 1 at the third LVAL fall (+2 cycles).
REQ-035 cl_port_j = 0xA5 for one LVAL cycle, other taps 0 → led8[3:0] = 0xA after FVAL fall.
REQ-036 LVAL pulses with FVAL = 0 → no counter change; reset asserted mid-line → led8 = 0 immediately.
